// File: rtl/ifc_comm_pkg.sv
// Shared definitions for the IFC block-write transmit path: framer states,
// default header byte, register window addresses and block command codes.
package ifc_comm_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HDR,
    ST_LEN_H,
    ST_LEN_L,
    ST_DAT_H,
    ST_DAT_L,
    ST_CSUM_H,
    ST_CSUM_L,
    ST_FIN
  } tx_state_e;

  localparam logic [7:0]  HDR_BYTE_DEF  = 8'hA5;

  localparam logic [7:0]  ADDR_BLK_CMD  = 8'h40;
  localparam logic [7:0]  ADDR_CSUM     = 8'h50;
  localparam logic [7:0]  ADDR_LEN      = 8'h52;
  localparam logic [7:0]  ADDR_DATA     = 8'h54;

  localparam logic [15:0] CMD_BLK_WRITE = 16'h0105;
  localparam logic [15:0] CMD_BLK_END   = 16'h0100;

  // ceil(len/2) without overflowing when len is 16'hFFFF
  function automatic logic [15:0] words_for_len(input logic [15:0] len);
    logic [16:0] t;
    t = {1'b0, len} + 17'd1;
    return t[16:1];
  endfunction

endpackage

// File: rtl/ifc_word_fifo.sv
// DEPTH x W synchronous FIFO with a registered head word; popping loads the
// next word into the head register so it is ready on the following cycle.
module ifc_word_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  head_q, head_d;
  logic          head_vld_q, head_vld_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_we, pop_ok, push_ok, push_head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = !head_vld_q;
  assign full  = head_vld_q && (cnt_q == CW'(DEPTH - 1));
  assign dout  = head_q;

  always_comb begin
    head_d     = head_q;
    head_vld_d = head_vld_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    mem_we     = 1'b0;
    pop_ok     = pop && head_vld_q;
    push_ok    = push && !full;
    // the head register takes the incoming word whenever storage is bypassable
    push_head  = push_ok && (!head_vld_q || (pop_ok && cnt_q == '0));
    if (flush) begin
      head_vld_d = 1'b0;
      rd_d       = '0;
      wr_d       = '0;
      cnt_d      = '0;
    end else begin
      if (pop_ok) begin
        if (cnt_q != '0) begin
          head_d = mem_q[rd_q];
          rd_d   = ptr_inc(rd_q);
          cnt_d  = cnt_q - CW'(1);
        end else begin
          head_vld_d = 1'b0;
        end
      end
      if (push_head) begin
        head_d     = din;
        head_vld_d = 1'b1;
      end else if (push_ok) begin
        mem_we = 1'b1;
        wr_d   = ptr_inc(wr_q);
        cnt_d  = cnt_d + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_vld_q <= 1'b0;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
    end else begin
      head_vld_q <= head_vld_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    head_q <= head_d;
    if (mem_we) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/ifc_block_tx_framer.sv
// Buffers a host block write and emits HDR, LEN_H, LEN_L, payload bytes and,
// with IFC_TX_CSUM_TRAILER_EN defined, a 16-bit checksum trailer to the UART.
module ifc_block_tx_framer
  import ifc_comm_pkg::*;
#(
  parameter int         DEPTH    = 8,
  parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEF
) (
  input  logic        clock_50MHz,
  input  logic        sys_rst,
  input  logic        start,
  input  logic        abort,
  input  logic        len_wr,
  input  logic [15:0] len_data,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done,
  output logic        err_len,
  output logic        err_ovf,
  output logic [15:0] checksum
);
  localparam logic [15:0] MAX_LEN = 16'(2 * DEPTH);
`ifdef IFC_TX_CSUM_TRAILER_EN
  localparam tx_state_e POST_DATA = ST_CSUM_H;
`else
  localparam tx_state_e POST_DATA = ST_FIN;
`endif

  tx_state_e   state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] csum_q, csum_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        err_len_q, err_len_d;
  logic        err_ovf_q, err_ovf_d;
  logic        fifo_push, fifo_pop, fifo_flush, fifo_empty, fifo_full;
  logic [15:0] fifo_dout, nwords;
  logic        xfer, last_word;

  function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
    return a + b;
  endfunction

  ifc_word_fifo #(.DEPTH(DEPTH), .W(16)) u_fifo (
    .clk   (clock_50MHz),
    .rst   (sys_rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (wr_data),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign nwords    = words_for_len(len_q);
  assign xfer      = tx_valid && tx_ready;
  // wcnt counts words up while loading and back down while sending
  assign last_word = (wcnt_q == 16'd1);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FIN);
  assign err_len   = err_len_q;
  assign err_ovf   = err_ovf_q;
  assign checksum  = csum_q;

  always_comb begin
    tx_data  = '0;
    tx_valid = 1'b1;
    case (state_q)
      ST_HDR:    tx_data = HDR_BYTE;
      ST_LEN_H:  tx_data = len_q[15:8];
      ST_LEN_L:  tx_data = len_q[7:0];
      ST_DAT_H:  tx_data = fifo_dout[15:8];
      ST_DAT_L:  tx_data = fifo_dout[7:0];
      ST_CSUM_H: tx_data = csum_q[15:8];
      ST_CSUM_L: tx_data = csum_q[7:0];
      default:   tx_valid = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    csum_d     = csum_q;
    wcnt_d     = wcnt_q;
    err_len_d  = err_len_q;
    err_ovf_d  = err_ovf_q;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (len_wr) begin
          if (len_data == '0 || len_data > MAX_LEN) begin
            err_len_d = 1'b1;
          end else begin
            len_d     = len_data;
            err_len_d = 1'b0;
          end
        end
        if (start && !err_len_q && len_q != '0) begin
          state_d    = ST_LOAD;
          csum_d     = '0;
          wcnt_d     = '0;
          err_ovf_d  = 1'b0;
          fifo_flush = 1'b1;
        end
      end
      ST_LOAD: begin
        if (wr_en) begin
          if (wcnt_q < nwords && !fifo_full) begin
            fifo_push = 1'b1;
            csum_d    = csum_add(csum_q, wr_data);
            wcnt_d    = wcnt_q + 16'd1;
            if (wcnt_q + 16'd1 == nwords) state_d = ST_HDR;
          end else begin
            err_ovf_d = 1'b1;
          end
        end
      end
      ST_HDR:    if (xfer) state_d = ST_LEN_H;
      ST_LEN_H:  if (xfer) state_d = ST_LEN_L;
      ST_LEN_L:  if (xfer) state_d = ST_DAT_H;
      ST_DAT_H: begin
        if (xfer) begin
          if (last_word && len_q[0]) begin
            fifo_pop = !fifo_empty;
            wcnt_d   = '0;
            state_d  = POST_DATA;
          end else begin
            state_d = ST_DAT_L;
          end
        end
      end
      ST_DAT_L: begin
        if (xfer) begin
          fifo_pop = !fifo_empty;
          wcnt_d   = wcnt_q - 16'd1;
          state_d  = last_word ? POST_DATA : ST_DAT_H;
        end
      end
      ST_CSUM_H: if (xfer) state_d = ST_CSUM_L;
      ST_CSUM_L: if (xfer) state_d = ST_FIN;
      ST_FIN:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (wr_en && state_q != ST_IDLE && state_q != ST_LOAD) err_ovf_d = 1'b1;
    // abort overrides everything; a word arriving with it is dropped and flagged
    if (abort) begin
      state_d    = ST_IDLE;
      csum_d     = csum_q;
      wcnt_d     = '0;
      err_ovf_d  = err_ovf_q | (wr_en && state_q != ST_IDLE);
      fifo_push  = 1'b0;
      fifo_pop   = 1'b0;
      fifo_flush = 1'b1;
    end
  end

  always_ff @(posedge clock_50MHz or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      csum_q    <= '0;
      wcnt_q    <= '0;
      err_len_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      csum_q    <= csum_d;
      wcnt_q    <= wcnt_d;
      err_len_q <= err_len_d;
      err_ovf_q <= err_ovf_d;
    end
  end

endmodule

// File: tb/tb_ifc_block_tx_framer.sv
// Randomized bench for ifc_block_tx_framer; expected frames are built from the
// framing rules (header, length, payload bytes, optional checksum trailer).
module tb_ifc_block_tx_framer;

  logic        clk = 1'b0;
  logic        sys_rst, start, abort, len_wr, wr_en, tx_ready;
  logic [15:0] len_data, wr_data;
  logic [7:0]  tx_data;
  logic        tx_valid, busy, done, err_len, err_ovf;
  logic [15:0] checksum;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] wbuf [8];

  always #10 clk = ~clk;

  ifc_block_tx_framer dut (
    .clock_50MHz (clk),
    .sys_rst     (sys_rst),
    .start       (start),
    .abort       (abort),
    .len_wr      (len_wr),
    .len_data    (len_data),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .done        (done),
    .err_len     (err_len),
    .err_ovf     (err_ovf),
    .checksum    (checksum)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic write_len(input int len);
    len_wr   = 1'b1;
    len_data = 16'(len);
    @(negedge clk);
    len_wr   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // ready_mode: 0 always ready, 1 ready one cycle in three, 2 random
  task automatic run_frame(input int len, input int ready_mode, input bit inject);
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [15:0] l16, s16;
    logic [7:0]  prev;
    int          sum, nw, done_cnt, post, cyc;
    bit          stall, injected, rdy;
    l16 = 16'(len);
    nw  = (len + 1) / 2;
    sum = 0;
    exp_q.push_back(8'hA5);
    exp_q.push_back(l16[15:8]);
    exp_q.push_back(l16[7:0]);
    for (int i = 0; i < nw; i++) begin
      exp_q.push_back(wbuf[i][15:8]);
      if (2 * i + 1 < len) exp_q.push_back(wbuf[i][7:0]);
      sum = (sum + int'(wbuf[i])) % 65536;
    end
    s16 = 16'(sum);
`ifdef IFC_TX_CSUM_TRAILER_EN
    exp_q.push_back(s16[15:8]);
    exp_q.push_back(s16[7:0]);
`endif
    write_len(len);
    pulse_start();
    for (int i = 0; i < nw; i++) begin
      repeat ($urandom_range(0, 1)) @(negedge clk);
      wr_en   = 1'b1;
      wr_data = wbuf[i];
      @(negedge clk);
      wr_en   = 1'b0;
    end
    check_eq("first_valid", 32'(tx_valid), 32'd1);
    done_cnt = 0; post = 0; cyc = 0; stall = 0; injected = 0; prev = '0;
    while (cyc < 500 && post < 3) begin
      start = 1'b0;
      wr_en = 1'b0;
      if (stall) begin
        check_eq("stall_valid", 32'(tx_valid), 32'd1);
        check_eq("stall_data", 32'(tx_data), 32'(prev));
      end
      if (done) done_cnt++;
      if (done_cnt > 0) post++;
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (inject && !injected && got_q.size() == 1 && tx_valid) begin
        start    = 1'b1;
        wr_en    = 1'b1;
        wr_data  = 16'hFFFF;
        injected = 1'b1;
      end
      tx_ready = rdy;
      if (tx_valid && rdy) got_q.push_back(tx_data);
      stall = tx_valid && !rdy;
      prev  = tx_data;
      @(negedge clk);
      cyc++;
    end
    tx_ready = 1'b0;
    check_eq("done_pulses", 32'(done_cnt), 32'd1);
    check_eq("frame_bytes", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_eq($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    check_eq("checksum", 32'(checksum), 32'(s16));
    check_eq("busy_after", 32'(busy), 32'd0);
    check_eq("err_ovf", 32'(err_ovf), 32'(inject));
  endtask

  initial begin
    int len, nvalid, ndone;
    sys_rst = 1'b1; start = 0; abort = 0; len_wr = 0; wr_en = 0; tx_ready = 0;
    len_data = '0; wr_data = '0;
    @(negedge clk);
    check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'({err_len, err_ovf}), 32'd0);
    check_eq("rst_checksum", 32'(checksum), 32'd0);
    @(negedge clk);
    sys_rst = 1'b0;
    @(negedge clk);

    // len=12 with fixed payload, first always ready, then throttled
    wbuf[0] = 16'h0112; wbuf[1] = 16'h3344; wbuf[2] = 16'h5566;
    wbuf[3] = 16'h0223; wbuf[4] = 16'h7788; wbuf[5] = 16'h99AA;
    run_frame(12, 0, 0);
    run_frame(12, 1, 0);

    wbuf[0] = 16'h1234; wbuf[1] = 16'h5678; wbuf[2] = 16'h9A00;
    run_frame(5, 0, 0);

    for (int f = 0; f < 6; f++) begin
      len = (f == 0) ? 16 : int'($urandom_range(1, 16));
      for (int i = 0; i < 8; i++) wbuf[i] = 16'($urandom);
      run_frame(len, 2, 0);
    end

    // rejected lengths block start; a valid length clears the error
    write_len(0);
    check_eq("err_len_zero", 32'(err_len), 32'd1);
    pulse_start();
    check_eq("start_blocked", 32'(busy), 32'd0);
    write_len(18);
    check_eq("err_len_big", 32'(err_len), 32'd1);
    pulse_start();
    check_eq("start_blocked2", 32'(busy), 32'd0);
    write_len(2);
    check_eq("err_len_clear", 32'(err_len), 32'd0);

    // abort during load with a coincident word
    write_len(4);
    pulse_start();
    wr_en = 1'b1; wr_data = 16'h1234;
    @(negedge clk);
    abort = 1'b1; wr_data = 16'h5555;
    @(negedge clk);
    abort = 1'b0; wr_en = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_err_ovf", 32'(err_ovf), 32'd1);
    check_eq("abort_partial_sum", 32'(checksum), 32'h1234);
    nvalid = 0; ndone = 0;
    for (int i = 0; i < 6; i++) begin
      if (tx_valid) nvalid++;
      if (done) ndone++;
      @(negedge clk);
    end
    check_eq("abort_no_valid", 32'(nvalid), 32'd0);
    check_eq("abort_no_done", 32'(ndone), 32'd0);

    // start and wr_en during emission are ignored / flagged
    wbuf[0] = 16'hBEEF;
    run_frame(2, 1, 1);

    // asynchronous reset mid-frame
    write_len(6);
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 16'(16'h1111 * (i + 1));
      @(negedge clk);
    end
    wr_en = 1'b0;
    @(negedge clk);
    check_eq("pre_rst_valid", 32'(tx_valid), 32'd1);
    #5 sys_rst = 1'b1;
    #1;
    check_eq("arst_valid", 32'(tx_valid), 32'd0);
    check_eq("arst_data", 32'(tx_data), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_checksum", 32'(checksum), 32'd0);
    @(negedge clk);
    sys_rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) wbuf[i] = 16'($urandom);
    run_frame(7, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
